run_monitor: RTL
================

// Module: run_monitor
// PURPOSE
//   Parametrised run controller for multi-core CPU simulation and FPGA bring-up.
//   Stretches the external reset into a fixed-length core reset, then counts cycles and retired instructions.
//   Detects completion when every core has halted, and flags a timeout on a global cycle limit or a retire stall.
//   Sits between the top-level clk/reset and the cpu instances; its status outputs drive the bench's $finish logic.
// PARAMETERS
//   NUM_CORES    1      number of monitored cores (>=1)
//   CNT_W        32     width of cycle and retire counters
//   RESET_CYCLES 2      cycles core_reset stays high after reset deasserts (>=1)
//   MAX_CYCLES   30000  global run-cycle limit; 0 disables it
//   WDOG_CYCLES  1024   consecutive cycles without any retire before a stall timeout; 0 disables it
// PORTS
//   clk          in   1          system clock, rising edge
//   reset        in   1          asynchronous, active-high reset
//   restart      in   1          sync pulse; from DONE/TIMEOUT re-enters HOLD
//   core_halt    in   NUM_CORES  per-core halt (syscall exit); level or pulse
//   core_retire  in   NUM_CORES  per-core instruction-retired strobe, 1/cycle
//   core_reset   out  1          reset to cores, active-high
//   status       out  2          00 HOLD, 01 RUN, 10 DONE, 11 TIMEOUT
//   stall_flag   out  1          1 = timeout caused by watchdog; 0 = timeout caused by MAX_CYCLES
//   halted_mask  out  NUM_CORES  sticky per-core halted flags
//   cycle_count  out  CNT_W      cycles spent in RUN, saturating
//   retire_count out  CNT_W      total retires over all cores in RUN, saturating
// BEHAVIOUR
//   - reset=1 (async): state HOLD; core_reset=1; status=00; stall_flag=0; halted_mask=0;
//     cycle_count=0; retire_count=0; hold counter=0; watchdog counter=0.
//   - HOLD: the hold counter increments each clk edge after reset deasserts.
//     After RESET_CYCLES edges the block moves to RUN, and core_reset falls on that same edge.
//   - RUN, per edge:
//     - cycle_count += 1.
//     - retire_count += popcount(core_retire & ~halted_mask).
//     - halted_mask |= core_halt.
//   - Retire/halt inputs are ignored outside RUN.
//   - A core's retire is ignored from the cycle after its halt bit is latched.
//   - Saturation: counters stop at all-ones; they never wrap.
//     The popcount add is computed at CNT_W+1 bits and clamped to all-ones.
//   - Watchdog:
//     - Clears on any qualifying retire; otherwise increments.
//     - Trips when it reaches WDOG_CYCLES.
//     - Halted cores do not retire, so the watchdog runs only while at least one core is not halted.
//   - Transitions out of RUN, in priority order:
//     1. (halted_mask | core_halt) all ones -> DONE.
//     2. cycle_count+1 == MAX_CYCLES -> TIMEOUT, stall_flag=0.
//     3. watchdog trip -> TIMEOUT, stall_flag=1.
//     DONE beats TIMEOUT when both occur on the same edge.
//   - DONE/TIMEOUT: terminal. Counters and halted_mask freeze; core_reset stays 0.
//   - restart=1 in DONE/TIMEOUT: next state HOLD.
//     Counters, halted_mask, stall_flag and watchdog clear; core_reset=1; the hold sequence reruns.
//     restart is ignored in HOLD/RUN.
//   - reset mid-RUN: immediate async return to the reset state; there is no partial-count retention.
//   - All outputs are registered; there is no combinational path from inputs to outputs.
// STRUCTURE
//   - The shared include run_defs.v holds:
//     - `define RUN_ST_HOLD 2'b00, RUN_ST_RUN 2'b01, RUN_ST_DONE 2'b10, RUN_ST_TIMEOUT 2'b11.
//     - A popcount function.
//   - Sub-module sat_counter #(W): clr, inc_en, inc[W:0], q.
//     - Saturating add.
//     - Instantiated for cycle_count, retire_count and the watchdog.
//   - The FSM, hold counter and halted_mask live in run_monitor.
// TESTING
//   1. Reset sequence (RESET_CYCLES=2): reset high 15ns, then low.
//      -> core_reset=1 for 2 edges after deassert, then 0; status 00->01; cycle_count=0 at entry to RUN.
//   2. Completion (NUM_CORES=2): core0 retires 10x and halts at cycle 12; core1 halts at cycle 20.
//      -> status=10 on the edge core1 halts; retire_count=10; halted_mask=11; cycle_count frozen at 20.
//   3. Global limit (MAX_CYCLES=100, retire every cycle, no halt).
//      -> status=11, stall_flag=0, cycle_count=100, retire_count=100.
//   4. Stall (WDOG_CYCLES=16): 5 retires, then none.
//      -> TIMEOUT with stall_flag=1 exactly 16 cycles after the last retire.
//   5. Halt and limit on the same edge (MAX_CYCLES=50, final halt at run cycle 50) -> status=10.
//   6. Saturation and reset handling:
//      - CNT_W=4: a 20-cycle run -> cycle_count=15.
//      - restart from DONE -> HOLD with all counters 0.
//      - Async reset asserted mid-clock -> outputs at reset values before the next edge.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// Shared state encodings and helpers for the run controller.
// The status output carries the raw state code, so these values are also the status legend.
package run_monitor_pkg;

  localparam logic [1:0] RUN_ST_HOLD    = 2'b00;
  localparam logic [1:0] RUN_ST_RUN     = 2'b01;
  localparam logic [1:0] RUN_ST_DONE    = 2'b10;
  localparam logic [1:0] RUN_ST_TIMEOUT = 2'b11;

  // Widest core vector the retire popcount accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_W = 64;

  function automatic logic [31:0] popcount(input logic [POP_W-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter: adds a (W+1)-bit increment and clamps at all-ones instead of wrapping.
// A clear takes priority over an increment on the same edge.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_en_i,
  input  logic [W:0]   inc_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic [W:0]   sum;

  always_comb begin
    sum = {1'b0, q_q} + inc_i;
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_en_i) begin
      q_d = sum[W] ? '1 : sum[W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/run_monitor.sv
// Run controller: stretches reset into a core reset, counts run cycles and retires,
// and ends the run on all-cores-halted (DONE) or on a cycle limit / retire stall (TIMEOUT).
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 1,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 30000,
  parameter int unsigned WDOG_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [NUM_CORES-1:0] core_halt,
  input  logic [NUM_CORES-1:0] core_retire,
  output logic                 core_reset,
  output logic [1:0]           status,
  output logic                 stall_flag,
  output logic [NUM_CORES-1:0] halted_mask,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     retire_count
);

  // hold_q counts 0..RESET_CYCLES-1; the watchdog never needs to hold more than WDOG_CYCLES-1.
  localparam int unsigned HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam int unsigned WD_W   = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);

  logic [1:0]           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic                 core_reset_q, core_reset_d;
  logic                 stall_q, stall_d;

  logic [CNT_W-1:0]     cycle_w;
  logic [CNT_W-1:0]     retire_w;
  logic [WD_W-1:0]      wdog_w;

  logic                 in_run;
  logic                 restart_go;
  logic [NUM_CORES-1:0] qual_retire;
  logic [NUM_CORES-1:0] mask_merged;
  logic                 all_halted;
  logic                 limit_hit;
  logic                 wdog_hit;
  logic [CNT_W:0]       retire_inc;

  assign in_run      = (state_q == RUN_ST_RUN);
  assign restart_go  = restart && ((state_q == RUN_ST_DONE) || (state_q == RUN_ST_TIMEOUT));
  // A core stops contributing retires once its halt bit is already latched.
  assign qual_retire = core_retire & ~mask_q;
  assign mask_merged = mask_q | core_halt;
  assign all_halted  = &mask_merged;
  assign retire_inc  = (CNT_W+1)'(popcount(POP_W'(qual_retire)));

  assign limit_hit = (MAX_CYCLES != 0) &&
                     ((64'(cycle_w) + 64'd1) == 64'(MAX_CYCLES));
  assign wdog_hit  = (WDOG_CYCLES != 0) && !(|qual_retire) &&
                     ((64'(wdog_w) + 64'd1) == 64'(WDOG_CYCLES));

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    mask_d       = mask_q;
    core_reset_d = core_reset_q;
    stall_d      = stall_q;
    case (state_q)
      RUN_ST_HOLD: begin
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d      = RUN_ST_RUN;
          hold_d       = '0;
          core_reset_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN_ST_RUN: begin
        mask_d = mask_merged;
        // Completion outranks both timeout causes on the same edge.
        if (all_halted) begin
          state_d = RUN_ST_DONE;
        end else if (limit_hit) begin
          state_d = RUN_ST_TIMEOUT;
          stall_d = 1'b0;
        end else if (wdog_hit) begin
          state_d = RUN_ST_TIMEOUT;
          stall_d = 1'b1;
        end
      end
      default: begin
        if (restart_go) begin
          state_d      = RUN_ST_HOLD;
          hold_d       = '0;
          mask_d       = '0;
          stall_d      = 1'b0;
          core_reset_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN_ST_HOLD;
      hold_q       <= '0;
      mask_q       <= '0;
      core_reset_q <= 1'b1;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      mask_q       <= mask_d;
      core_reset_q <= core_reset_d;
      stall_q      <= stall_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (restart_go),
    .inc_en_i (in_run),
    .inc_i    ((CNT_W+1)'(1)),
    .q_o      (cycle_w)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (restart_go),
    .inc_en_i (in_run),
    .inc_i    (retire_inc),
    .q_o      (retire_w)
  );

  // Watchdog restarts from zero on every counted retire and otherwise ticks once per run cycle.
  sat_counter #(.W(WD_W)) u_wdog_cnt (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (restart_go || (in_run && (|qual_retire))),
    .inc_en_i (in_run),
    .inc_i    ((WD_W+1)'(1)),
    .q_o      (wdog_w)
  );

  assign core_reset   = core_reset_q;
  assign status       = state_q;
  assign stall_flag   = stall_q;
  assign halted_mask  = mask_q;
  assign cycle_count  = cycle_w;
  assign retire_count = retire_w;

endmodule
